// File: rtl/div_unit.sv
// div_unit: multi-cycle signed divider (restoring, one quotient bit per clock).
// Quotient goes to divLo and remainder to divHi. The quotient truncates toward
// zero and the remainder takes the dividend's sign.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high reset
//   DivCtrl  start request, sampled only while idle
//   A, B     dividend / divisor, two's complement, sampled at the start edge
//   divLo    registered quotient
//   divHi    registered remainder
//   divDone  one-cycle completion pulse
//   divZero  divide-by-zero flag, pulses together with divDone
//   divBusy  high while an operation is in progress or completing
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] divLo,
  output logic [WIDTH-1:0] divHi,
  output logic             divDone,
  output logic             divZero,
  output logic             divBusy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] rq_q, rq_d;       // {partial remainder, quotient/dividend}
  logic [WIDTH-1:0]   absb_q, absb_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sgn_quo_q, sgn_quo_d;
  logic               sgn_rem_q, sgn_rem_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;

  logic [2*WIDTH-1:0] rq_shift;
  logic [2*WIDTH-1:0] rq_step;

  // Magnitude as unsigned: the most negative value maps onto itself, which
  // is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic            neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // State register and all datapath flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rq_q      <= '0;
      absb_q    <= '0;
      count_q   <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rq_q      <= rq_d;
      absb_q    <= absb_d;
      count_q   <= count_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      zero_q    <= zero_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (DivCtrl) state_d = (B == '0) ? DONE : RUN;
      RUN:     if (count_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One restoring step. The partial remainder is always below |B| <= 2^(W-1),
  // so the shifted upper half never loses a significant bit.
  always_comb begin
    rq_shift = rq_q << 1;
    rq_step  = rq_shift;
    if (rq_shift[2*WIDTH-1:WIDTH] >= absb_q) begin
      rq_step[2*WIDTH-1:WIDTH] = rq_shift[2*WIDTH-1:WIDTH] - absb_q;
      rq_step[0]               = 1'b1;
    end
  end

  // Datapath next values
  always_comb begin
    rq_d      = rq_q;
    absb_d    = absb_q;
    count_d   = count_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    zero_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (DivCtrl) begin
          if (B == '0) begin
            zero_d = 1'b1;
          end else begin
            rq_d      = {{WIDTH{1'b0}}, abs_val(A)};
            absb_d    = abs_val(B);
            count_d   = '0;
            sgn_quo_d = A[WIDTH-1] ^ B[WIDTH-1];
            sgn_rem_d = A[WIDTH-1];
          end
        end
      end
      RUN: begin
        rq_d    = rq_step;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          lo_d = cond_neg(rq_step[WIDTH-1:0], sgn_quo_q);
          hi_d = cond_neg(rq_step[2*WIDTH-1:WIDTH], sgn_rem_q);
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    divLo   = lo_q;
    divHi   = hi_q;
    divBusy = (state_q != IDLE);
    divDone = (state_q == DONE);
    divZero = (state_q == DONE) && zero_q;
  end

endmodule
